// File: rtl/avg_arbiter.sv
// avg_arbiter: round-robin arbiter sharing one 2**LOG2N-sample window averager.
// Ports: CLK/RST(sync, high); REQ->GNT grant; NUM/VALID/READY in; AVE/AVE_ID/AVE_PARTIAL/AVE_VALID/AVE_READY out.
module avg_arbiter #(
  parameter int NREQ  = 2,
  parameter int W     = 4,
  parameter int LOG2N = 3
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [NREQ-1:0] REQ,
  output logic [NREQ-1:0] GNT,
  input  logic [W-1:0]    NUM,
  input  logic            VALID,
  output logic            READY,
  output logic [W-1:0]    AVE,
  output logic [1:0]      AVE_ID,
  output logic            AVE_PARTIAL,
  output logic            AVE_VALID,
  input  logic            AVE_READY
);

  localparam int SAMPLES = 2 ** LOG2N;
  localparam int AW      = W + LOG2N;
  localparam int CW      = LOG2N + 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    OUT
  } state_e;

  state_e          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [1:0]      gid_q, gid_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    ave_q, ave_d;
  logic [1:0]      ave_id_q, ave_id_d;
  logic            part_q, part_d;

  logic            found;
  logic [1:0]      pick_id;
  logic [NREQ-1:0] pick_oh;
  logic [AW-1:0]   sum;
  logic            last;
  logic            own;

  // First requester at or after the pointer, wrapping.
  always_comb begin
    found   = 1'b0;
    pick_id = '0;
    pick_oh = '0;
    for (int i = 0; i < NREQ; i++) begin
      int idx;
      idx = (int'(ptr_q) + i) % NREQ;
      if (!found && REQ[idx]) begin
        found        = 1'b1;
        pick_id      = 2'(idx);
        pick_oh      = '0;
        pick_oh[idx] = 1'b1;
      end
    end
  end

  assign sum  = acc_q + AW'(NUM);
  assign last = (cnt_q == CW'(SAMPLES - 1));
  assign own  = |(REQ & gnt_q);

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    gid_d    = gid_q;
    ptr_d    = ptr_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    ave_d    = ave_q;
    ave_id_d = ave_id_q;
    part_d   = part_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = ACCUM;
          gnt_d   = pick_oh;
          gid_d   = pick_id;
          acc_d   = '0;
          cnt_d   = '0;
          if (int'(pick_id) + 1 == NREQ) ptr_d = '0;
          else                           ptr_d = pick_id + 2'd1;
        end
      end
      ACCUM: begin
        if (VALID) begin
          acc_d = sum;
          cnt_d = cnt_q + CW'(1);
          // A full window wins over a same-cycle REQ drop.
          if (last) begin
            state_d  = OUT;
            ave_d    = W'(sum >> LOG2N);
            ave_id_d = gid_q;
            part_d   = 1'b0;
          end
        end else if (!own) begin
          // Divisor stays SAMPLES even for a short window.
          state_d  = OUT;
          ave_d    = W'(acc_q >> LOG2N);
          ave_id_d = gid_q;
          part_d   = 1'b1;
        end
      end
      OUT: begin
        if (AVE_READY) begin
          state_d = IDLE;
          gnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      gid_q    <= '0;
      ptr_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      ave_q    <= '0;
      ave_id_q <= '0;
      part_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      gid_q    <= gid_d;
      ptr_q    <= ptr_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      ave_q    <= ave_d;
      ave_id_q <= ave_id_d;
      part_q   <= part_d;
    end
  end

  assign GNT         = gnt_q;
  assign READY       = (state_q == ACCUM);
  assign AVE_VALID   = (state_q == OUT);
  assign AVE         = ave_q;
  assign AVE_ID      = ave_id_q;
  assign AVE_PARTIAL = part_q;

endmodule

// File: tb/tb_avg_arbiter.sv
// tb_avg_arbiter: directed checks of avg_arbiter with default parameters.
// Drives inputs after each edge, samples outputs 1 time unit past the edge.
module tb_avg_arbiter;

  logic       CLK = 1'b0;
  logic       RST;
  logic [1:0] REQ;
  logic [1:0] GNT;
  logic [3:0] NUM;
  logic       VALID;
  logic       READY;
  logic [3:0] AVE;
  logic [1:0] AVE_ID;
  logic       AVE_PARTIAL;
  logic       AVE_VALID;
  logic       AVE_READY;

  int n_tests = 0;
  int n_fail  = 0;

  avg_arbiter dut (
    .CLK        (CLK),
    .RST        (RST),
    .REQ        (REQ),
    .GNT        (GNT),
    .NUM        (NUM),
    .VALID      (VALID),
    .READY      (READY),
    .AVE        (AVE),
    .AVE_ID     (AVE_ID),
    .AVE_PARTIAL(AVE_PARTIAL),
    .AVE_VALID  (AVE_VALID),
    .AVE_READY  (AVE_READY)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [1:0] g,
                         input logic rdy, input logic [3:0] a,
                         input logic [1:0] id, input logic p,
                         input logic v);
    chk({tag, ".gnt"}, 32'(GNT), 32'(g));
    chk({tag, ".ready"}, 32'(READY), 32'(rdy));
    chk({tag, ".ave"}, 32'(AVE), 32'(a));
    chk({tag, ".id"}, 32'(AVE_ID), 32'(id));
    chk({tag, ".partial"}, 32'(AVE_PARTIAL), 32'(p));
    chk({tag, ".valid"}, 32'(AVE_VALID), 32'(v));
  endtask

  task automatic feed(input logic [3:0] v, input int n);
    VALID = 1'b1;
    NUM   = v;
    for (int k = 0; k < n; k++) step();
    VALID = 1'b0;
  endtask

  initial begin
    RST = 1'b1; REQ = '0; NUM = '0; VALID = 1'b0; AVE_READY = 1'b1;
    step();
    step();
    chk_out("reset", 2'b00, 0, 0, 0, 0, 0);
    RST = 1'b0;

    // Full window of 1..8 from requester 0.
    REQ = 2'b01;
    step();
    chk("full.grant", 32'(GNT), 32'd1);
    chk("full.ready", 32'(READY), 32'd1);
    VALID = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      NUM = 4'(k);
      if (k == 8) REQ = 2'b00;
      step();
    end
    VALID = 1'b0;
    chk_out("full.out", 2'b01, 0, 4, 0, 0, 1);
    step();
    chk_out("full.done", 2'b00, 0, 4, 0, 0, 0);

    // Round robin from a fresh reset with both requesting.
    RST = 1'b1;
    step();
    RST = 1'b0;
    REQ = 2'b11;
    step();
    chk("rr.g0", 32'(GNT), 32'd1);
    feed(4'd2, 8);
    chk_out("rr.out0", 2'b01, 0, 2, 0, 0, 1);
    step();
    chk("rr.idle0", 32'(GNT), 32'd0);
    step();
    chk("rr.g1", 32'(GNT), 32'd2);
    feed(4'd3, 8);
    chk_out("rr.out1", 2'b10, 0, 3, 1, 0, 1);
    step();
    chk("rr.idle1", 32'(GNT), 32'd0);
    step();
    chk("rr.g2", 32'(GNT), 32'd1);
    // Zero-sample window: owner drops with nothing sent.
    REQ = 2'b00;
    step();
    chk_out("rr.empty", 2'b01, 0, 0, 0, 1, 1);
    step();
    chk("rr.idle2", 32'(AVE_VALID), 32'd0);

    // Partial window from requester 1, then backpressure.
    REQ = 2'b10;
    step();
    chk("part.grant", 32'(GNT), 32'd2);
    feed(4'd15, 3);
    REQ = 2'b00;
    AVE_READY = 1'b0;
    step();
    chk_out("part.out", 2'b10, 0, 5, 1, 1, 1);
    for (int k = 0; k < 5; k++) begin
      step();
      chk_out("bp.hold", 2'b10, 0, 5, 1, 1, 1);
    end
    AVE_READY = 1'b1;
    step();
    chk_out("bp.release", 2'b00, 0, 5, 1, 1, 0);

    // Final sample and REQ drop in the same cycle.
    REQ = 2'b01;
    step();
    chk("sim.grant", 32'(GNT), 32'd1);
    feed(4'd15, 7);
    REQ   = 2'b00;
    VALID = 1'b1;
    NUM   = 4'd15;
    step();
    VALID = 1'b0;
    chk_out("sim.out", 2'b01, 0, 15, 0, 0, 1);
    step();
    chk("sim.done", 32'(AVE_VALID), 32'd0);

    // Reset part-way through a window.
    REQ = 2'b01;
    step();
    chk("rst.grant", 32'(GNT), 32'd1);
    feed(4'd15, 4);
    RST = 1'b1;
    step();
    chk_out("rst.mid", 2'b00, 0, 0, 0, 0, 0);
    RST = 1'b0;
    step();
    chk("rst.regrant", 32'(GNT), 32'd1);
    feed(4'd8, 8);
    chk_out("rst.out", 2'b01, 0, 8, 0, 0, 1);
    REQ = 2'b00;
    step();
    chk("rst.done", 32'(AVE_VALID), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
